// File: rtl/sh1_ext_bus_bridge.sv
// Bridge from the SH-1 chip-select/strobe bus to NUM_CS request/acknowledge
// memory ports; owns WAITN, the read-data return path and the sticky error flags.
module sh1_ext_bus_bridge #(
  parameter int NUM_CS   = 4,
  parameter int AW       = 22,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic [AW-1:0]     A,
  input  logic [15:0]       DO,
  input  logic [NUM_CS-1:0] CSN,
  input  logic              RDN,
  input  logic              WRHN,
  input  logic              WRLN,
  output logic [15:0]       DI,
  output logic              WAITN,
  output logic [AW-1:0]     MEM_A,
  output logic [15:0]       MEM_DO,
  output logic [1:0]        MEM_BE,
  output logic              MEM_WE,
  output logic [NUM_CS-1:0] MEM_REQ,
  input  logic [NUM_CS-1:0] MEM_ACK,
  input  logic [15:0]       MEM_DI,
  output logic              TO_ERR,
  output logic              MULTI_CS,
  input  logic              ERR_CLR
);

  localparam int CH_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TO_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CH_W-1:0] ch, ch_sel;
  logic            multi_sel;
  int              n_low;
  logic [3:0]      wait_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            ack_latch;
  logic [15:0]     rd_data;

  logic cs_any, strobe_any, released, wait_ok, to_hit, ack_now;
  logic start, done_ack, done_to;

  assign cs_any     = ~&CSN;
  assign strobe_any = ~(RDN & WRHN & WRLN);
  // The access ends as soon as the core drops its chip select or all strobes.
  assign released   = CSN[ch] | (RDN & WRHN & WRLN);
  // Counters are compared post-increment, so MIN_WAIT and TIMEOUT count CE_R
  // periods from the start edge to the release edge.
  assign wait_ok    = ({1'b0, wait_cnt} + 5'd1) >= 5'(MIN_WAIT);
  assign to_hit     = (to_cnt == TO_W'(TIMEOUT - 1));
  assign ack_now    = |(MEM_ACK & MEM_REQ);

  // Lowest-index active chip select wins; more than one low is flagged.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    ch_sel = '0;
    n_low  = 0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (!CSN[i]) begin
        ch_sel = CH_W'(i);
        n_low  = n_low + 1;
      end
    end
    multi_sel = (n_low > 1);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    // NOTE: non-blocking so every register samples the pre-edge values of the others.
    else        state <= state_next;
  end

  // Next-state logic; all transitions happen only on CE_R.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    if (CE_R) begin
      case (state)
        IDLE: begin
          if (cs_any && strobe_any) begin
            start      = 1'b1;
            state_next = REQ;
          end
        end
        REQ: begin
          // A latched ack always beats a coincident timeout.
          if (ack_latch && wait_ok) begin
            done_ack   = 1'b1;
            state_next = released ? IDLE : HOLD;
          end else if (!ack_latch && to_hit) begin
            done_to    = 1'b1;
            state_next = released ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (released) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from state so an async reset drops them immediately.
  always_comb begin
    WAITN   = (state != REQ);
    MEM_REQ = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      MEM_REQ[i] = (state == REQ) && (ch == CH_W'(i));
    end
  end

  // Access latches, counters, ack capture and the read-data return path.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ch        <= '0;
      MEM_A     <= '0;
      MEM_DO    <= '0;
      MEM_BE    <= '0;
      MEM_WE    <= 1'b0;
      wait_cnt  <= '0;
      to_cnt    <= '0;
      ack_latch <= 1'b0;
      rd_data   <= '0;
      DI        <= 16'hFFFF;
    end else begin
      // Acks arrive on any CLK edge, not only on CE_R.
      if (ack_now) begin
        ack_latch <= 1'b1;
        rd_data   <= MEM_DI;
      end

      if (start) begin
        ch        <= ch_sel;
        MEM_A     <= A;
        MEM_DO    <= DO;
        MEM_WE    <= ~(WRHN & WRLN);
        MEM_BE    <= (WRHN & WRLN) ? 2'b11 : {~WRHN, ~WRLN};
        wait_cnt  <= '0;
        to_cnt    <= '0;
        ack_latch <= 1'b0;
      end

      if (CE_R && (state == REQ)) begin
        if (wait_cnt != 4'd15) wait_cnt <= wait_cnt + 4'd1;
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (done_ack && !MEM_WE) DI <= rd_data;
      if (done_to)             DI <= 16'hFFFF;

      // Leaving for IDLE (from REQ on abort, or from HOLD) re-arms the ack latch.
      if ((state != IDLE) && (state_next == IDLE)) ack_latch <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as ERR_CLR wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TO_ERR   <= 1'b0;
      MULTI_CS <= 1'b0;
    end else begin
      if (ERR_CLR) begin
        TO_ERR   <= 1'b0;
        MULTI_CS <= 1'b0;
      end
      if (done_to)             TO_ERR   <= 1'b1;
      if (start && multi_sel)  MULTI_CS <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sh1_ext_bus_bridge.sv
// Bench for sh1_ext_bus_bridge: directed vector table, abort and reset
// sequences, and randomized accesses checked against a latency/data model.
module tb_sh1_ext_bus_bridge;

  localparam int TB_MIN_WAIT = 1;
  localparam int TB_TIMEOUT  = 8;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R;
  logic [21:0] A;
  logic [15:0] DO;
  logic [3:0]  CSN;
  logic        RDN, WRHN, WRLN;
  logic [15:0] DI;
  logic        WAITN;
  logic [21:0] MEM_A;
  logic [15:0] MEM_DO;
  logic [1:0]  MEM_BE;
  logic        MEM_WE;
  logic [3:0]  MEM_REQ;
  logic [3:0]  MEM_ACK;
  logic [15:0] MEM_DI;
  logic        TO_ERR, MULTI_CS, ERR_CLR;

  sh1_ext_bus_bridge #(
    .NUM_CS(4), .AW(22), .MIN_WAIT(TB_MIN_WAIT), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .DO(DO), .CSN(CSN),
    .RDN(RDN), .WRHN(WRHN), .WRLN(WRLN), .DI(DI), .WAITN(WAITN),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
    .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK), .MEM_DI(MEM_DI),
    .TO_ERR(TO_ERR), .MULTI_CS(MULTI_CS), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  csn;
    logic        rdn, wrhn, wrln;
    logic [21:0] addr;
    logic [15:0] dout, mdi;
    int          ack_k;      // ack pulsed in the gap after CE_R edge ack_k
    logic [3:0]  exp_req;
    logic        exp_we;
    logic [1:0]  exp_be;
    int          exp_lat;    // CE_R periods WAITN stays low
    logic [15:0] exp_di;
    logic        exp_to, exp_multi;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_di;
  vec_t        tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One CLK cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ce);
    CE_R = ce;
    @(posedge CLK);
    #1;
    CE_R = 1'b0;
  endtask

  task automatic idle_bus();
    CSN = '1; RDN = 1'b1; WRHN = 1'b1; WRLN = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int         lat;
    bit         done;
    logic [3:0] spur;
    spur = {v.exp_req[2:0], v.exp_req[3]};
    A = v.addr; DO = v.dout; CSN = v.csn; RDN = v.rdn; WRHN = v.wrhn; WRLN = v.wrln;
    step(1'b1);
    check({tag, ".req"},   MEM_REQ, v.exp_req);
    check({tag, ".we"},    MEM_WE,  v.exp_we);
    check({tag, ".be"},    MEM_BE,  v.exp_be);
    check({tag, ".addr"},  MEM_A,   v.addr);
    check({tag, ".dout"},  MEM_DO,  v.dout);
    check({tag, ".waitn"}, WAITN,   1'b0);
    lat  = 0;
    done = 0;
    for (int p = 0; p < 40 && !done; p++) begin
      if (p == v.ack_k) begin
        MEM_ACK = v.exp_req; MEM_DI = v.mdi;
      end else if (p == 0) begin
        MEM_ACK = spur; MEM_DI = ~v.mdi;    // ack on an idle channel must be ignored
      end
      step(1'b0);
      MEM_ACK = '0;
      step(1'b1);
      if (WAITN) begin
        lat  = p + 1;
        done = 1;
      end
    end
    check({tag, ".lat"},      lat,      v.exp_lat);
    check({tag, ".di"},       DI,       v.exp_di);
    check({tag, ".to_err"},   TO_ERR,   v.exp_to);
    check({tag, ".multi"},    MULTI_CS, v.exp_multi);
    check({tag, ".req_off"},  MEM_REQ,  4'b0000);
    // Strobes still held: no second request may be issued.
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    check({tag, ".single"},   MEM_REQ,  4'b0000);
    check({tag, ".to_held"},  TO_ERR,   v.exp_to);
    idle_bus();
    step(1'b0); step(1'b1); step(1'b0);
    ERR_CLR = 1'b1;
    step(1'b0);
    ERR_CLR = 1'b0;
    check({tag, ".to_clr"},    TO_ERR,   1'b0);
    check({tag, ".multi_clr"}, MULTI_CS, 1'b0);
    model_di = v.exp_di;
  endtask

  // Reference model: derive every expectation from the access rules.
  function automatic vec_t model_txn(input logic [3:0] csn, input int typ,
                                     input logic [21:0] addr, input logic [15:0] dout,
                                     input logic [15:0] mdi, input int k,
                                     input logic [15:0] prev_di);
    vec_t v;
    int   ch, arrival;
    bit   is_wr;
    ch = 0;
    for (int i = 3; i >= 0; i--) if (!csn[i]) ch = i;
    is_wr       = (typ != 0);
    v.csn       = csn;
    v.rdn       = is_wr;
    v.wrhn      = !(typ == 1 || typ == 3);
    v.wrln      = !(typ == 2 || typ == 3);
    v.addr      = addr;
    v.dout      = dout;
    v.mdi       = mdi;
    v.ack_k     = k;
    v.exp_req   = 4'(1 << ch);
    v.exp_we    = is_wr;
    v.exp_be    = is_wr ? {1'(typ == 1 || typ == 3), 1'(typ == 2 || typ == 3)} : 2'b11;
    v.exp_multi = ($countones(~csn) > 1);
    arrival     = k + 1;
    if (arrival <= TB_TIMEOUT) begin
      v.exp_lat = (TB_MIN_WAIT > arrival) ? TB_MIN_WAIT : arrival;
      v.exp_di  = is_wr ? prev_di : mdi;
      v.exp_to  = 1'b0;
    end else begin
      v.exp_lat = TB_TIMEOUT;
      v.exp_di  = 16'hFFFF;
      v.exp_to  = 1'b1;
    end
    return v;
  endfunction

  initial begin
    RST_N = 1'b0; CE_R = 1'b0; A = '0; DO = '0; MEM_ACK = '0; MEM_DI = '0; ERR_CLR = 1'b0;
    idle_bus();
    model_di = 16'hFFFF;

    //            csn     rdn  wrhn wrln addr        dout      mdi       k   req     we   be     lat di        to   multi
    tbl[0] = '{4'b1011, 1'b0, 1'b1, 1'b1, 22'h012345, 16'h0000, 16'hA55A, 1, 4'b0100, 1'b0, 2'b11, 2, 16'hA55A, 1'b0, 1'b0};
    tbl[1] = '{4'b1101, 1'b1, 1'b1, 1'b0, 22'h00ABCD, 16'h12EF, 16'h7777, 0, 4'b0010, 1'b1, 2'b01, 1, 16'hA55A, 1'b0, 1'b0};
    tbl[2] = '{4'b1110, 1'b0, 1'b1, 1'b1, 22'h3FFFFF, 16'h0000, 16'h1111, 99, 4'b0001, 1'b0, 2'b11, 8, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{4'b1001, 1'b0, 1'b1, 1'b1, 22'h000100, 16'h0000, 16'h1234, 2, 4'b0010, 1'b0, 2'b11, 3, 16'h1234, 1'b0, 1'b1};
    tbl[4] = '{4'b0111, 1'b1, 1'b0, 1'b1, 22'h2AAAAA, 16'hBEEF, 16'h0F0F, 4, 4'b1000, 1'b1, 2'b10, 5, 16'h1234, 1'b0, 1'b0};
    tbl[5] = '{4'b1101, 1'b0, 1'b1, 1'b1, 22'h015555, 16'h0000, 16'hC3C3, 7, 4'b0010, 1'b0, 2'b11, 8, 16'hC3C3, 1'b0, 1'b0};
    tbl[6] = '{4'b1011, 1'b0, 1'b0, 1'b0, 22'h000777, 16'h5A5A, 16'h0000, 3, 4'b0100, 1'b1, 2'b11, 4, 16'hC3C3, 1'b0, 1'b0};

    // Reset state.
    step(1'b0); step(1'b0); step(1'b0);
    check("rst.di",     DI,       16'hFFFF);
    check("rst.waitn",  WAITN,    1'b1);
    check("rst.req",    MEM_REQ,  4'b0000);
    check("rst.addr",   MEM_A,    22'h0);
    check("rst.dout",   MEM_DO,   16'h0);
    check("rst.be",     MEM_BE,   2'b00);
    check("rst.we",     MEM_WE,   1'b0);
    check("rst.to_err", TO_ERR,   1'b0);
    check("rst.multi",  MULTI_CS, 1'b0);
    RST_N = 1'b1;
    step(1'b0); step(1'b0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Abort: strobes dropped during REQ, ack five periods later, then an
    // immediate access on another channel proves the bridge skipped HOLD.
    A = 22'h000055; CSN = 4'b1110; RDN = 1'b0;
    step(1'b1);
    step(1'b0); step(1'b1);
    idle_bus();
    for (int p = 1; p < 5; p++) begin
      step(1'b0); step(1'b1);
    end
    check("abort.req_held", MEM_REQ, 4'b0001);
    check("abort.waitn",    WAITN,   1'b0);
    MEM_ACK = 4'b0001; MEM_DI = 16'h6B6B;
    step(1'b0);
    MEM_ACK = '0;
    step(1'b1);
    check("abort.done_waitn", WAITN,   1'b1);
    check("abort.done_req",   MEM_REQ, 4'b0000);
    check("abort.di",         DI,      16'h6B6B);
    A = 22'h000003; CSN = 4'b0111; RDN = 1'b0;
    step(1'b0); step(1'b1);
    check("abort.next_req",   MEM_REQ, 4'b1000);
    MEM_ACK = 4'b1000; MEM_DI = 16'h9999;
    step(1'b0);
    MEM_ACK = '0;
    step(1'b1);
    check("abort.next_waitn", WAITN, 1'b1);
    check("abort.next_di",    DI,    16'h9999);
    idle_bus();
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    model_di = 16'h9999;

    // Randomized accesses against the model.
    for (int n = 0; n < 24; n++) begin
      vec_t v;
      v = model_txn(4'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                    22'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 9)), model_di);
      run_txn(v, $sformatf("rnd%0d", n));
    end

    // Async reset in the middle of a request.
    A = 22'h000444; CSN = 4'b1011; RDN = 1'b0;
    step(1'b1);
    step(1'b0); step(1'b1);
    check("rreset.pre_req", MEM_REQ, 4'b0100);
    #2 RST_N = 1'b0;
    #1;
    check("rreset.waitn", WAITN,   1'b1);
    check("rreset.req",   MEM_REQ, 4'b0000);
    check("rreset.di",    DI,      16'hFFFF);
    check("rreset.addr",  MEM_A,   22'h0);
    idle_bus();
    step(1'b0);
    RST_N = 1'b1;
    step(1'b0); step(1'b0);
    run_txn(model_txn(4'b1101, 0, 22'h001F00, 16'h0000, 16'h4C4C, 1, 16'hFFFF), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
